tmds_encoder_mc: RTL and testbench
==================================

Name: tmds_encoder_mc

Overview:
- Parametrised multi-channel TMDS/HDMI encoder, the successor to the single-channel DVI encoder.
- Encodes CHANNELS lanes in parallel and adds HDMI data-island (TERC4) and guard-band modes on top of video and control.
- Two-stage registered pipeline; one DC-balance disparity counter per lane.
- Sits between the video/packet scheduler and the 10:1 serialisers.

Parameters:
- CHANNELS, 3, number of TMDS lanes encoded in parallel (1..8).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- mode  in  3  0=CTRL, 1=VIDEO, 2=VIDEO_GB, 3=DATA (TERC4), 4=DATA_GB; 5..7 are treated as CTRL
- data  in  8*CHANNELS  video byte per lane; lane k uses [8k+7:8k]
- ctrl  in  2*CHANNELS  control pair {c1,c0} per lane; lane k uses [2k+1:2k]
- terc4  in  4*CHANNELS  TERC4 nibble per lane; lane k uses [4k+3:4k]
- out  out  10*CHANNELS  TMDS symbol per lane; bit 0 is transmitted first, bit 9 is the inversion flag

Behaviour:
- Reset is synchronous, active-high, on clk only. In the cycle after rst is sampled high:
  - all pipeline registers are cleared (mode=CTRL, ctrl=0);
  - every lane's out = 1101010100;
  - every disparity counter = 0.
- Inputs are sampled every clk; there is no stall. Latency is exactly 2 cycles: inputs at edge N appear on out after edge N+2.
- Stage 1, per lane:
  - N1 = popcount(data). Use XNOR if N1>4, or if N1==4 and data[0]==0; otherwise XOR.
  - q_m[0]=data[0]; q_m[i] = q_m[i-1] xor/xnor data[i] for i=1..7.
  - q_m[8] = 0 for XNOR, 1 for XOR.
  - Register q_m, n1q = popcount(q_m[7:0]), mode, ctrl and terc4.
- Stage 2 VIDEO, per lane. cnt is a 5-bit signed counter; diff = n1q - (8 - n1q).
  - If cnt==0 or diff==0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m[8] ? diff : -diff
  - Else if (cnt>0 and diff>0) or (cnt<0 and diff<0):
    - out = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] - diff
  - Else:
    - out = {0, q_m[8], q_m[7:0]}
    - cnt += diff - 2*(~q_m[8])
  - cnt stays in the range -8..+8 with even values only; it must never wrap.
- Stage 2 CTRL: out is chosen by ctrl:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- Stage 2 DATA: out = TERC4(terc4), nibble 0..F ->
  - 1010011100, 1001100011, 1011100100, 1011100010
  - 0101110001, 0100011110, 0110001110, 0100111100
  - 1011001100, 0100111001, 0110011100, 1011000110
  - 1010001110, 1001110001, 0101100011, 1011000011
- Stage 2 VIDEO_GB: even-index lanes output 1011001100; odd-index lanes output 0100110011.
- Stage 2 DATA_GB: lane 0 outputs TERC4(terc4 lane 0); lanes >=1 output 0100110011.
- Any non-VIDEO mode in stage 2 forces that lane's cnt to 0. The first VIDEO symbol after any blanking therefore starts at cnt=0.
- Lanes are fully independent; only mode is shared across lanes.
- Mode changes take effect per symbol with no bubble. A VIDEO->CTRL->VIDEO sequence one cycle apart is legal.
- Reset asserted mid-stream:
  - symbols already in the pipeline are discarded;
  - out shows the reset code for every cycle rst is high plus one further cycle;
  - real symbols resume 2 cycles after rst falls.

Test Plan:
- Reset: hold rst 3 cycles with mode=VIDEO, data=0xFF -> every lane's out = 1101010100 through 1 cycle after rst falls; first real symbol appears 2 cycles after deassertion.
- Disparity, lane 0: after CTRL, send VIDEO data=0x00 three times -> out = 0100000000, 1111111111, 0100000000; cnt = -8, +2, -6.
- XNOR path: cnt=0, VIDEO data=0xFF -> out = 1000000000, cnt = -8. Then mode=CTRL for 1 cycle, then data=0xFF again -> same 1000000000 (cnt restarted at 0).
- Control and TERC4: CTRL with ctrl 00/01/10/11 -> the four control codes above. DATA with terc4 = 0x0, 0x8, 0xF -> 1010011100, 1011001100, 1011000011.
- Guard bands, CHANNELS=3: VIDEO_GB -> lanes 0/1/2 = 1011001100 / 0100110011 / 1011001100. DATA_GB with lane 0 terc4=0xC -> lane 0 = 1010001110, lanes 1/2 = 0100110011.
- Random: 10k cycles of random mode/data on CHANNELS=4 compared against a reference model. Check 2-cycle latency, cnt always even and within -8..+8, and per-lane independence; run once with mode=7 -> CTRL output.

Source files
------------

// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS/HDMI symbol encoder: video (8b/10b with DC balance), control,
// TERC4 data-island and guard-band symbols, two registered stages per lane.
module tmds_encoder_mc #(
    parameter int CHANNELS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               mode,
    input  logic [8*CHANNELS-1:0]    data,
    input  logic [2*CHANNELS-1:0]    ctrl,
    input  logic [4*CHANNELS-1:0]    terc4,
    output logic [10*CHANNELS-1:0]   out
);

    localparam logic [2:0] MODE_CTRL     = 3'd0;
    localparam logic [2:0] MODE_VIDEO    = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GB = 3'd2;
    localparam logic [2:0] MODE_DATA     = 3'd3;
    localparam logic [2:0] MODE_DATA_GB  = 3'd4;

    localparam logic [9:0] GB_EVEN = 10'b1011001100;
    localparam logic [9:0] GB_ODD  = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] t);
        case (t)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    logic [9*CHANNELS-1:0]  qm_p1_d,    qm_p1_q;
    logic [4*CHANNELS-1:0]  n1q_p1_d,   n1q_p1_q;
    logic [2:0]             mode_p1_q;
    logic [2*CHANNELS-1:0]  ctrl_p1_q;
    logic [4*CHANNELS-1:0]  terc4_p1_q;
    logic [10*CHANNELS-1:0] out_p2_d,   out_p2_q;
    logic signed [4:0]      cnt_d [CHANNELS];
    logic signed [4:0]      cnt_q [CHANNELS];

    // Stage 1: transition-minimising q_m per lane
    always_comb begin
        logic [7:0] d;
        logic [8:0] qm;
        logic [3:0] n1;
        logic       use_xnor;
        qm_p1_d  = '0;
        n1q_p1_d = '0;
        d        = '0;
        qm       = '0;
        n1       = '0;
        use_xnor = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            d        = data[8*k +: 8];
            n1       = popcount8(d);
            use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
            qm[0]    = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8]    = ~use_xnor;
            qm_p1_d[9*k +: 9]  = qm;
            n1q_p1_d[4*k +: 4] = popcount8(qm[7:0]);
        end
    end

    // Stage 2: symbol selection and per-lane running disparity
    always_comb begin
        logic [8:0]        qm;
        logic [3:0]        n1q;
        logic signed [5:0] diff;
        logic signed [5:0] cnt6;
        logic signed [5:0] cnt_n;
        logic [9:0]        sym;
        out_p2_d = '0;
        qm       = '0;
        n1q      = '0;
        diff     = '0;
        cnt6     = '0;
        cnt_n    = '0;
        sym      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            qm    = qm_p1_q[9*k +: 9];
            n1q   = n1q_p1_q[4*k +: 4];
            diff  = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
            cnt6  = {cnt_q[k][4], cnt_q[k]};
            cnt_n = '0;
            case (mode_p1_q)
                MODE_VIDEO: begin
                    if (cnt_q[k] == 5'sd0 || diff == 6'sd0) begin
                        sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                        cnt_n = qm[8] ? (cnt6 + diff) : (cnt6 - diff);
                    end else if ((cnt_q[k] > 5'sd0 && diff > 6'sd0) ||
                                 (cnt_q[k] < 5'sd0 && diff < 6'sd0)) begin
                        sym   = {1'b1, qm[8], ~qm[7:0]};
                        cnt_n = cnt6 + (qm[8] ? 6'sd2 : 6'sd0) - diff;
                    end else begin
                        sym   = {1'b0, qm[8], qm[7:0]};
                        cnt_n = cnt6 + diff - (qm[8] ? 6'sd0 : 6'sd2);
                    end
                end
                MODE_VIDEO_GB: sym = (k % 2 == 0) ? GB_EVEN : GB_ODD;
                MODE_DATA:     sym = terc4_code(terc4_p1_q[4*k +: 4]);
                MODE_DATA_GB:  sym = (k == 0) ? terc4_code(terc4_p1_q[3:0]) : GB_ODD;
                default:       sym = ctrl_code(ctrl_p1_q[2*k +: 2]);
            endcase
            cnt_d[k] = cnt_n[4:0];
            out_p2_d[10*k +: 10] = sym;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qm_p1_q    <= '0;
            n1q_p1_q   <= '0;
            mode_p1_q  <= MODE_CTRL;
            ctrl_p1_q  <= '0;
            terc4_p1_q <= '0;
            out_p2_q   <= {CHANNELS{ctrl_code(2'b00)}};
            for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
        end else begin
            qm_p1_q    <= qm_p1_d;
            n1q_p1_q   <= n1q_p1_d;
            mode_p1_q  <= mode;
            ctrl_p1_q  <= ctrl;
            terc4_p1_q <= terc4;
            out_p2_q   <= out_p2_d;
            for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign out = out_p2_q;

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Scoreboard bench for tmds_encoder_mc with four lanes: directed encodings plus
// a long random run against an independent behavioural model.
module tb_tmds_encoder_mc;

    localparam int C = 4;
    localparam int W = 10 * C;
    localparam logic [9:0] RST_CODE = 10'b1101010100;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2:0]     mode = 3'd0;
    logic [8*C-1:0] data = '0;
    logic [2*C-1:0] ctrl = '0;
    logic [4*C-1:0] terc4 = '0;
    logic [W-1:0]   out;

    tmds_encoder_mc #(.CHANNELS(C)) dut (
        .clk(clk), .rst(rst), .mode(mode), .data(data),
        .ctrl(ctrl), .terc4(terc4), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] exp;
        bit           hc;
        logic [W-1:0] cv;
        string        tag;
    } sb_t;

    sb_t sbq[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  mcnt [C];

    logic [9:0] ctrl_tab  [4]  = '{10'b1101010100, 10'b0010101011,
                                   10'b0101010100, 10'b1010101011};
    logic [9:0] terc4_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                   10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                   10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                   10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: out=%b expected=%b", tag, got, exp);
        end
    endtask

    // Reference: q_m built from prefix parity, XNOR path inverts odd positions.
    task automatic model(input logic [2:0] m, input logic [8*C-1:0] d, input logic [2*C-1:0] c,
                         input logic [4*C-1:0] t, output logic [W-1:0] e);
        logic [7:0] b;
        logic [8:0] qm;
        logic [9:0] s;
        logic       p;
        bit         xn;
        int         ones, n1q, diff;
        e = '0;
        for (int k = 0; k < C; k++) begin
            b    = d[8*k +: 8];
            ones = $countones(b);
            xn   = (ones > 4) || (ones == 4 && b[0] == 1'b0);
            p    = 1'b0;
            for (int i = 0; i < 8; i++) begin
                p     = p ^ b[i];
                qm[i] = p ^ (xn && (i % 2 == 1));
            end
            qm[8] = !xn;
            n1q   = $countones(qm[7:0]);
            diff  = 2 * n1q - 8;
            case (m)
                3'd1: begin
                    if (mcnt[k] == 0 || diff == 0) begin
                        s = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
                        mcnt[k] += qm[8] ? diff : -diff;
                    end else if ((mcnt[k] > 0) == (diff > 0)) begin
                        s = {1'b1, qm[8], ~qm[7:0]};
                        mcnt[k] += 2 * int'(qm[8]) - diff;
                    end else begin
                        s = {1'b0, qm[8], qm[7:0]};
                        mcnt[k] += diff - 2 * int'(!qm[8]);
                    end
                end
                3'd2: s = (k % 2 == 1) ? 10'b0100110011 : 10'b1011001100;
                3'd3: s = terc4_tab[t[4*k +: 4]];
                3'd4: s = (k == 0) ? terc4_tab[t[3:0]] : 10'b0100110011;
                default: s = ctrl_tab[c[2*k +: 2]];
            endcase
            if (m != 3'd1) mcnt[k] = 0;
            e[10*k +: 10] = s;
        end
    endtask

    // One cycle: retire the entry driven two cycles ago, then drive and predict.
    task automatic step(input logic r, input logic [2:0] m, input logic [8*C-1:0] d,
                        input logic [2*C-1:0] c, input logic [4*C-1:0] t,
                        input bit hc, input logic [W-1:0] cv, input string tag);
        sb_t e;
        logic [W-1:0] pred;
        @(negedge clk);
        if (sbq.size() == 2) begin
            e = sbq.pop_front();
            check_vec(e.tag, out, e.exp);
            if (e.hc) check_vec({e.tag, "_const"}, out, e.cv);
        end
        rst = r; mode = m; data = d; ctrl = c; terc4 = t;
        if (r) begin
            foreach (sbq[i]) begin
                sbq[i].exp = {C{RST_CODE}};
                sbq[i].hc  = 1'b0;
            end
            for (int k = 0; k < C; k++) mcnt[k] = 0;
            pred = {C{RST_CODE}};
        end else begin
            model(m, d, c, t, pred);
        end
        e.exp = pred; e.hc = hc; e.cv = cv; e.tag = tag;
        sbq.push_back(e);
    endtask

    initial begin
        logic [2:0]     rm;
        logic [8*C-1:0] rd;
        logic [2*C-1:0] rc;
        logic [4*C-1:0] rt;
        logic [W-1:0]   z;
        z = '0;
        for (int k = 0; k < C; k++) mcnt[k] = 0;

        // reset held three cycles with live video on the inputs
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd1, {C{8'hFF}}, '0, '0, 1'b1, {C{RST_CODE}}, "reset");
        step(1'b0, 3'd1, {C{8'hFF}}, '0, '0, 1'b1, {C{10'b1000000000}}, "xnor_first");
        step(1'b0, 3'd0, '0, '0, '0, 1'b1, {C{RST_CODE}}, "ctrl_gap");
        step(1'b0, 3'd1, {C{8'hFF}}, '0, '0, 1'b1, {C{10'b1000000000}}, "xnor_restart");

        step(1'b0, 3'd0, '0, '0, '0, 1'b0, z, "ctrl");
        step(1'b0, 3'd1, '0, '0, '0, 1'b1, {C{10'b0100000000}}, "disp0");
        step(1'b0, 3'd1, '0, '0, '0, 1'b1, {C{10'b1111111111}}, "disp1");
        step(1'b0, 3'd1, '0, '0, '0, 1'b1, {C{10'b0100000000}}, "disp2");

        step(1'b0, 3'd0, {C{8'hA5}}, {C{2'b00}}, '0, 1'b1, {C{10'b1101010100}}, "ctrl00");
        step(1'b0, 3'd0, {C{8'hA5}}, {C{2'b01}}, '0, 1'b1, {C{10'b0010101011}}, "ctrl01");
        step(1'b0, 3'd0, {C{8'hA5}}, {C{2'b10}}, '0, 1'b1, {C{10'b0101010100}}, "ctrl10");
        step(1'b0, 3'd0, {C{8'hA5}}, {C{2'b11}}, '0, 1'b1, {C{10'b1010101011}}, "ctrl11");
        step(1'b0, 3'd3, '0, '0, {C{4'h0}}, 1'b1, {C{10'b1010011100}}, "terc4_0");
        step(1'b0, 3'd3, '0, '0, {C{4'h8}}, 1'b1, {C{10'b1011001100}}, "terc4_8");
        step(1'b0, 3'd3, '0, '0, {C{4'hF}}, 1'b1, {C{10'b1011000011}}, "terc4_F");
        step(1'b0, 3'd2, '0, '0, '0, 1'b1,
             {10'b0100110011, 10'b1011001100, 10'b0100110011, 10'b1011001100}, "video_gb");
        step(1'b0, 3'd4, '0, '0, {4'h3, 4'h5, 4'h9, 4'hC}, 1'b1,
             {10'b0100110011, 10'b0100110011, 10'b0100110011, 10'b1010001110}, "data_gb");
        step(1'b0, 3'd7, '0, {C{2'b10}}, '0, 1'b1, {C{10'b0101010100}}, "mode7");

        // lanes carry different bytes; video/ctrl/video back to back
        step(1'b0, 3'd1, {8'h00, 8'hFF, 8'h0F, 8'h81}, '0, '0, 1'b0, z, "lanes_v0");
        step(1'b0, 3'd0, '0, {2'b11, 2'b01, 2'b10, 2'b00}, '0, 1'b0, z, "lanes_c");
        step(1'b0, 3'd1, {8'h3C, 8'h01, 8'hFE, 8'h55}, '0, '0, 1'b0, z, "lanes_v1");

        for (int n = 0; n < 10000; n++) begin
            rm = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
            rd = {$urandom, $urandom};
            rc = 8'($urandom);
            rt = 16'($urandom);
            step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, rm, rd, rc, rt, 1'b0, z, "rand");
        end

        step(1'b0, 3'd0, '0, '0, '0, 1'b0, z, "drain");
        step(1'b0, 3'd0, '0, '0, '0, 1'b0, z, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
